// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-responder FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } state_e;

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI3 read-address and read-data channels between a read master and the responder.
interface axi_rd_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [4:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/rd_skid_fifo.sv
// Two-entry R-beat buffer holding {data, last, resp}; the caller never pushes when full.
module rd_skid_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic [1:0]        i_resp,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic [1:0]        o_resp,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic [1:0]        r_resp [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_resp[0] <= '0;
      r_resp[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_last[r_wr_ptr] <= i_last;
        r_resp[r_wr_ptr] <= i_resp;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_data[r_rd_ptr];
  assign o_last  = r_last[r_rd_ptr];
  assign o_resp  = r_resp[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/axi_rd_responder.sv
// AXI3 read responder: one AR at a time, one SRAM read per cycle, 2-entry R buffer.
// Optional start-address range check (SLVERR) enabled by AXI_RD_RESP_ERR_EN.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(32'h0000_0000),
  parameter logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(32'h0003_FFFF)
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_rd_responder_if.slave axi,
  output logic              ram_en,
  output logic [ADDR_W-3:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [4:0]        r_len;
  logic [1:0]        r_burst;
  logic [5:0]        r_iss_cnt;
  logic [5:0]        r_ret_cnt;
  logic              r_inflight;

  logic              w_accept;
  logic              w_arready;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic [DATA_W-1:0] w_push_data;
  logic [1:0]        w_push_resp;
  logic              w_push_last;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_last;
  logic [1:0]        w_head_resp;

  assign w_pop  = (w_count != 2'd0) && axi.rready;
  assign w_push = r_inflight;
  // Credit counts the beat leaving this cycle so a steady stream issues every cycle.
  assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_arready = 1'b1;
        if (axi.arvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = StBusy;
        end
      end
      StBusy: begin
        w_issue = (w_occ < 3'd2);
        // This issue makes iss_cnt reach arlen+1.
        if (w_issue && (r_iss_cnt == {1'b0, r_len})) begin
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && w_head_last && (w_count == 2'd1) && !w_push) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_burst    <= BURST_FIXED;
      r_iss_cnt  <= '0;
      r_ret_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_id      <= axi.arid;
        r_addr    <= axi.araddr;
        r_len     <= axi.arlen;
        r_burst   <= axi.arburst;
        r_iss_cnt <= '0;
        r_ret_cnt <= '0;
      end else begin
        if (w_issue) begin
          r_iss_cnt <= r_iss_cnt + 6'd1;
          if (r_burst != BURST_FIXED) begin
            r_addr <= r_addr + ADDR_W'(4);
          end
        end
        if (w_push) begin
          r_ret_cnt <= r_ret_cnt + 6'd1;
        end
      end
    end
  end

  assign w_push_last = (r_ret_cnt == {1'b0, r_len});

`ifdef AXI_RD_RESP_ERR_EN
  logic r_err;
  logic w_unused;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= (axi.araddr < ADDR_LO) || (axi.araddr > ADDR_HI);
    end
  end

  // Error bursts keep the issue timing but never touch the SRAM.
  assign ram_en      = w_issue && !r_err;
  assign w_push_data = r_err ? '0 : ram_rdata;
  assign w_push_resp = r_err ? RESP_SLVERR : RESP_OKAY;
  assign w_unused    = ^{axi.arsize, axi.arlock, axi.arcache, axi.arprot};
`else
  logic w_unused;

  assign ram_en      = w_issue;
  assign w_push_data = ram_rdata;
  assign w_push_resp = RESP_OKAY;
  assign w_unused    = ^{axi.arsize, axi.arlock, axi.arcache, axi.arprot, ADDR_LO, ADDR_HI};
`endif

  assign ram_addr = r_addr[ADDR_W-1:2];

  rd_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_push (w_push),
    .i_data (w_push_data),
    .i_last (w_push_last),
    .i_resp (w_push_resp),
    .i_pop  (w_pop),
    .o_data (w_head_data),
    .o_last (w_head_last),
    .o_resp (w_head_resp),
    .o_count(w_count)
  );

  assign axi.arready = w_arready;
  assign axi.rvalid  = (w_count != 2'd0);
  assign axi.rdata   = w_head_data;
  assign axi.rlast   = w_head_last;
  assign axi.rresp   = w_head_resp;
  assign axi.rid     = r_id;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: table-driven bursts plus a mid-burst reset sequence.
module tb_axi_rd_responder;
  import axi_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              ram_en;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       mem [4096];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [4:0]  len;
    logic [1:0]  burst;
    logic [31:0] rr_pat;
    logic [31:0] d0;
    logic [31:0] dstep;
    logic [1:0]  resp;
    bit          ram_on;
    logic [29:0] ra0;
    logic [29:0] rastep;
    int          first_cyc;
    int          last_cyc;
    int          idle_cyc;
  } vec_t;

  vec_t vecs[$];

  axi_rd_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_rd_responder #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .axi      (axi),
    .ram_en   (ram_en),
    .ram_addr (ram_addr),
    .ram_rdata(ram_rdata)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (ram_en) ram_rdata <= mem[ram_addr[11:0]];
  end

  always @(posedge aclk) begin
    if (aresetn && axi.arvalid && axi.arready)
      assert (axi.arsize == SIZE_4B) else $error("arsize is not 4 bytes per beat");
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr,
                              input logic [4:0] len, input logic [1:0] burst,
                              input logic [31:0] pat, input logic [31:0] d0,
                              input logic [31:0] dstep, input logic [1:0] resp,
                              input bit ram_on, input logic [29:0] ra0,
                              input logic [29:0] rastep, input int first_cyc,
                              input int last_cyc, input int idle_cyc);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.rr_pat = pat;
    v.d0 = d0; v.dstep = dstep; v.resp = resp; v.ram_on = ram_on; v.ra0 = ra0;
    v.rastep = rastep; v.first_cyc = first_cyc; v.last_cyc = last_cyc; v.idle_cyc = idle_cyc;
    return v;
  endfunction

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [4:0] len,
                          input logic [1:0] burst);
    axi.arvalid = 1'b1;
    axi.arid    = id;
    axi.araddr  = addr;
    axi.arlen   = len;
    axi.arburst = burst;
    axi.arsize  = SIZE_4B;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int          beats;
    int          issued;
    int          done_cyc;
    bit          stalled;
    logic [31:0] held_d;
    logic        held_l;
    string       tag;
    tag = $sformatf("v%0d", n);
    beats = 0; issued = 0; done_cyc = -1; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    @(negedge aclk);
    axi.rready = 1'b1;
    drive_ar(v.id, v.addr, v.len, v.burst);
    #1 chk({tag, "_arready_accept"}, 32'(axi.arready), 32'd1);
    for (int c = 1; c <= 120; c++) begin
      @(negedge aclk);
      if (c == 1) begin
        // Scramble AR inputs so the bench notices if the DUT fails to latch them.
        axi.arvalid = 1'b0;
        axi.araddr  = 32'hFFFF_FFF0;
        axi.arlen   = 5'h1F;
        axi.arid    = 4'hF;
        axi.arburst = BURST_FIXED;
      end
      axi.rready = v.rr_pat[(c - 1) % 32];
      #1;
      if (done_cyc >= 0) begin
        chk({tag, "_arready_after"}, 32'(axi.arready), 32'd1);
        chk({tag, "_rvalid_after"}, 32'(axi.rvalid), 32'd0);
        if (v.idle_cyc != 0) chk({tag, "_idle_cycle"}, 32'(c), 32'(v.idle_cyc));
        break;
      end
      if (c == 1) chk({tag, "_arready_busy"}, 32'(axi.arready), 32'd0);
      if (ram_en) begin
        if (v.ram_on) chk({tag, "_ram_addr"}, 32'(ram_addr), 32'(v.ra0 + 30'(issued) * v.rastep));
        issued++;
      end
      if (axi.rvalid) begin
        if (beats == 0 && v.first_cyc != 0) chk({tag, "_first_cycle"}, 32'(c), 32'(v.first_cyc));
        if (stalled) begin
          chk({tag, "_hold_data"}, axi.rdata, held_d);
          chk({tag, "_hold_last"}, 32'(axi.rlast), 32'(held_l));
        end
        chk({tag, "_rdata"}, axi.rdata, v.d0 + 32'(beats) * v.dstep);
        chk({tag, "_rlast"}, 32'(axi.rlast), 32'(beats == int'(v.len)));
        chk({tag, "_rid"}, 32'(axi.rid), 32'(v.id));
        chk({tag, "_rresp"}, 32'(axi.rresp), 32'(v.resp));
        if (axi.rready) begin
          if (axi.rlast) begin
            done_cyc = c;
            if (v.last_cyc != 0) chk({tag, "_last_cycle"}, 32'(c), 32'(v.last_cyc));
          end
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = axi.rdata;
          held_l  = axi.rlast;
        end
      end
      if (v.ram_on) chk({tag, "_outstanding_le2"}, 32'((issued - beats) <= 2), 32'd1);
    end
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_rlast required=rlast_within_budget", tag);
    end
    chk({tag, "_beats"}, 32'(beats), 32'(v.len) + 32'd1);
    chk({tag, "_issued"}, 32'(issued), v.ram_on ? 32'(v.len) + 32'd1 : 32'd0);
    axi.rready = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_arready"}, 32'(axi.arready), 32'd1);
    chk({tag, "_rvalid"}, 32'(axi.rvalid), 32'd0);
    chk({tag, "_rlast"}, 32'(axi.rlast), 32'd0);
    chk({tag, "_rdata"}, axi.rdata, 32'd0);
    chk({tag, "_rid"}, 32'(axi.rid), 32'd0);
    chk({tag, "_rresp"}, 32'(axi.rresp), 32'd0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
  endtask

  initial begin
    int  beats;
    bit  hit;
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    mem[12'h040] = 32'hDEAD_BEEF;
    axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
    axi.arsize = SIZE_4B; axi.arburst = BURST_INCR; axi.arlock = '0;
    axi.arcache = '0; axi.arprot = '0; axi.rready = 1'b1;

    repeat (2) @(negedge aclk);
    #1 chk_reset_state("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // id, addr, len, burst, rready pattern, d0, dstep, resp, ram_on, ra0, rastep, first, last, idle
    vecs.push_back(mk(4'h1, 32'h0000_0100, 5'd0, BURST_INCR, '1, 32'hDEAD_BEEF, 32'd0,
                      RESP_OKAY, 1'b1, 30'h40, 30'd0, 3, 3, 4));
    vecs.push_back(mk(4'h3, 32'h0000_1000, 5'd15, BURST_INCR, '1, 32'h400, 32'd1,
                      RESP_OKAY, 1'b1, 30'h400, 30'd1, 3, 18, 19));
    vecs.push_back(mk(4'h7, 32'h0000_0020, 5'd3, BURST_FIXED, '1, 32'h8, 32'd0,
                      RESP_OKAY, 1'b1, 30'h8, 30'd0, 3, 6, 7));
    vecs.push_back(mk(4'hA, 32'h0000_0200, 5'd7, BURST_INCR, 32'hFFFF_D8E9, 32'h80, 32'd1,
                      RESP_OKAY, 1'b1, 30'h80, 30'd1, 0, 0, 0));
    vecs.push_back(mk(4'hC, 32'h0000_0040, 5'd2, 2'b11, '1, 32'h10, 32'd1,
                      RESP_OKAY, 1'b1, 30'h10, 30'd1, 3, 5, 6));
`ifdef AXI_RD_RESP_ERR_EN
    vecs.push_back(mk(4'h2, 32'h0004_0000, 5'd3, BURST_INCR, '1, 32'h0, 32'd0,
                      RESP_SLVERR, 1'b0, 30'h0, 30'd0, 3, 6, 7));
    vecs.push_back(mk(4'h4, 32'h0003_FFFC, 5'd0, BURST_INCR, '1, 32'hFFF, 32'd0,
                      RESP_OKAY, 1'b1, 30'hFFFF, 30'd0, 3, 3, 4));
`endif

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset on the 5th beat of an INCR16, then a clean single-beat read.
    @(negedge aclk);
    drive_ar(4'h5, 32'h0000_1000, 5'd15, BURST_INCR);
    axi.rready = 1'b1;
    beats = 0;
    hit = 1'b0;
    for (int c = 1; c <= 60 && !hit; c++) begin
      @(negedge aclk);
      if (c == 1) axi.arvalid = 1'b0;
      #1;
      if (axi.rvalid) begin
        if (beats == 4) begin
          chk("mid_rdata_beat5", axi.rdata, 32'h404);
          hit = 1'b1;
          aresetn = 1'b0;
          #1 chk_reset_state("mid_reset");
        end else begin
          beats++;
        end
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL mid_reset_timeout actual=no_5th_beat required=5th_beat");
      aresetn = 1'b0;
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("post_reset_rvalid", 32'(axi.rvalid), 32'd0);
    run_vec(mk(4'h9, 32'h0000_0300, 5'd0, BURST_INCR, '1, 32'hC0, 32'd0,
               RESP_OKAY, 1'b1, 30'hC0, 30'd0, 3, 3, 4), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

AXI3-style read responder (slave) serving the read-address and read-data channels driven by the cache read-port merge. It accepts one AR request at a time, walks the burst address sequence, and reads a synchronous single-port SRAM one word per cycle. It returns R beats through a 2-entry output buffer that absorbs `rready` back-pressure. It serves as the memory endpoint for cache and SoC-level simulation and as the template for on-chip ROM/SRAM slaves.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; only 32 is supported.
- `ADDR_LO`, 32'h0000_0000, lowest legal byte address (used only with `AXI_RD_RESP_ERR_EN`).
- `ADDR_HI`, 32'h0003_FFFF, highest legal byte address (used only with `AXI_RD_RESP_ERR_EN`).
- `aclk` in 1: clock; all logic is rising-edge.
- `aresetn` in 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `arid` in 4: request ID, returned on `rid`.
- `araddr` in ADDR_W: start byte address.
- `arlen` in 5: beats minus one; 0..31.
- `arsize` in 3: bytes per beat, log2; only 3'b010 is legal.
- `arburst` in 2: 00 FIXED, 01 INCR; 10/11 treated as INCR.
- `arlock`/`arcache`/`arprot` in 2/4/3: accepted and ignored.
- `arvalid` in 1; `arready` out 1.
- `rid` out 4; `rdata` out DATA_W; `rresp` out 2; `rlast` out 1; `rvalid` out 1; `rready` in 1.
- `ram_en` out 1: SRAM read strobe.
- `ram_addr` out ADDR_W-2: word address (`addr[ADDR_W-1:2]`).
- `ram_rdata` in DATA_W: SRAM data, valid the cycle after `ram_en`.

## Operation
- FSM states:
  - IDLE: `arready`=1.
  - BUSY: issuing SRAM reads and draining beats.
  - DRAIN: all reads issued; waiting for the buffer to empty.
- IDLE→BUSY on `arvalid&&arready`. The block latches `arid`, `araddr`, `arlen`, `arburst`, and clears the issue counter `iss_cnt` and return counter `ret_cnt` (6 bits each).
- Issue rule in BUSY: `ram_en`=1 when `buf_count + inflight < 2`. `inflight` is the 1-bit flag "ram_en was asserted last cycle".
  - After each issue: `iss_cnt`++.
  - INCR: address += 4.
  - FIXED: address is unchanged.
  - The address wraps modulo 2^ADDR_W.
- BUSY→DRAIN when `iss_cnt == arlen+1` after an issue.
- `ram_rdata` is written into the buffer on the edge ending the cycle after `ram_en`, with `last = (ret_cnt == arlen)`. `ret_cnt`++ on each write.
- Buffer head drives `rdata`/`rlast`/`rresp`; `rvalid` = buffer non-empty. The head pops on `rvalid&&rready`.
- DRAIN→IDLE on the pop of the beat with `rlast`=1, provided the buffer becomes empty.
- `rid` holds the latched ID for the whole burst.
- The credit rule guarantees the buffer never overflows, so there is no dropped-beat path.
- Simultaneous push and pop at count 2 cannot occur; push and pop at count 1 keep count 1.
- `arvalid` while not IDLE is ignored (`arready`=0); the request is accepted once IDLE is re-entered.
- `arsize != 3'b010`: the block behaves as if 3'b010. This is flagged as a bench assertion, not a hardware error.

## Timing
- All outputs take their reset values immediately on `aresetn`=0:
  - `arready`=1 (IDLE).
  - `rvalid`=0, `rlast`=0, `rdata`=0, `rid`=0, `rresp`=2'b00.
  - `ram_en`=0, `ram_addr`=0.
- Reset mid-burst aborts the burst, flushes the buffer, and drops the in-flight SRAM word. After release the block is in IDLE.
- With an AR handshake in cycle T and `rready`=1 held:
  - `ram_en` is first asserted in T+1.
  - The first `rvalid` is in T+3.
  - There is one beat per cycle after that.
  - For `arlen`=15, `rlast` occurs in T+18 and `arready`=1 again in T+19.
- Under back-pressure, throughput tracks `rready` with no bubbles beyond the 2-cycle SRAM refill after a stall of two or more cycles.
- `rdata`/`rlast`/`rresp`/`rid` stay stable while `rvalid && !rready`.

## Configuration
- Macro: `AXI_RD_RESP_ERR_EN`.
- Defined:
  - At AR acceptance, `araddr` is compared against [`ADDR_LO`, `ADDR_HI`].
  - If outside the range, no `ram_en` is issued.
  - The block returns `arlen+1` beats with `rdata`=0 and `rresp`=2'b10 (SLVERR), using the same latency and `rlast` rules.
  - In-range bursts return `rresp`=2'b00. Only the start address is checked.
- Undefined: the comparator is absent, `ADDR_LO`/`ADDR_HI` are unused, and `rresp` is constant 2'b00.

## Structure
- Shared package `axi_pkg`:
  - Burst encodings `BURST_FIXED`/`BURST_INCR`.
  - Response codes `RESP_OKAY`/`RESP_SLVERR`.
  - `SIZE_4B` = 3'b010.
  - FSM state typedef.
- One sub-module: `rd_skid_fifo`, a 2-entry FIFO with payload {data, last, resp}, count output, and synchronous push/pop with asynchronous clear.

## Test plan
- Single read: `araddr`=0x100, `arlen`=0, INCR, `rready`=1, SRAM word 0x40 = 0xDEADBEEF. Expect exactly one beat with `rdata`=0xDEADBEEF and `rlast`=1, `rvalid` 3 cycles after the AR handshake, and `arready`=1 the next cycle.
- INCR16: `araddr`=0x1000, `arlen`=15, SRAM holding its word index. Expect `ram_addr` 0x400..0x40F, `rdata` 0x400..0x40F, one beat per cycle, `rlast` only on the 16th beat, `rid` equal to `arid`=4'h3 throughout.
- FIXED4 at 0x20. Expect four beats all equal to mem[0x8] and `ram_addr` constant at 0x8.
- Back-pressure: INCR8 with `rready` toggled 1,0,0,1,0,1... Expect every beat delivered in order with no loss or duplication, payload stable while stalled, and buffer count never above 2.
- Reset mid-burst: assert `aresetn`=0 on the 5th beat of an INCR16. Expect `rvalid`=0 immediately. A new INCR1 request after release returns correct data with no stale beats.
- With `AXI_RD_RESP_ERR_EN`: `araddr`=0x0004_0000, `arlen`=3. Expect 4 beats with `rresp`=2'b10, `rdata`=0, and `ram_en` never asserted. An in-range request next returns `rresp`=2'b00.
